// File: rtl/crypto_pkg.sv
// Shared cipher constants: forward/inverse 4-bit S-box tables and the substitution-layer states.
package crypto_pkg;

    // Packed [15:0][3:0] tables: the leftmost literal digit is entry 15.
    localparam logic [15:0][3:0] INV_SBOX_TABLE = 64'hA970_364B_D21C_8FE5;
    localparam logic [15:0][3:0] SBOX_TABLE     = 64'h2174_8FE3_DA09_B65C;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } inv_sbox_state_t;

endpackage

// File: rtl/inv_sbox.sv
// Combinational 4-bit inverse S-box lookup.
module inv_sbox
    import crypto_pkg::*;
(
    input  logic [3:0] data_i,
    output logic [3:0] data_o
);

    assign data_o = INV_SBOX_TABLE[data_i];

endmodule

// File: rtl/sbox.sv
// Forward 4-bit S-box lookup; elaborated only when INV_SBOX_SELFCHECK_EN is defined.
`ifdef INV_SBOX_SELFCHECK_EN
module SBox
    import crypto_pkg::*;
(
    input  logic [3:0] data_i,
    output logic [3:0] data_o
);

    assign data_o = SBOX_TABLE[data_i];

endmodule
`endif

// File: rtl/inv_sbox_layer.sv
// Sequential inverse S-box layer, LANES nibbles per cycle, valid/ready on both sides.
// Optional forward re-substitution self-check enabled by INV_SBOX_SELFCHECK_EN.
module inv_sbox_layer
    import crypto_pkg::*;
#(
    parameter int unsigned NIBBLES = 16,
    parameter int unsigned LANES   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_data,
    output logic                   busy,
    output logic                   check_err
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned LW    = 4 * LANES;
    localparam int unsigned STEPS = NIBBLES / LANES;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    if (LANES == 0 || (NIBBLES % LANES) != 0) begin : g_bad_lanes
        $error("inv_sbox_layer: LANES must divide NIBBLES");
    end

    inv_sbox_state_t  state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     blk_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [LW-1:0]    sub_lo;
    logic [W-1:0]     blk_rot;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_sbox u_inv_sbox (
            .data_i (blk_q[4*g +: 4]),
            .data_o (sub_lo[4*g +: 4])
        );
    end

    // Substituted low lanes re-enter at the top; after STEPS rotations order is restored.
    assign blk_rot = W'({sub_lo, blk_q} >> LW);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            blk_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_q    <= RUN;
                        blk_q      <= in_data;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    blk_q <= blk_rot;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= DONE;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = blk_q;
    assign busy      = busy_q;

`ifdef INV_SBOX_SELFCHECK_EN
    logic [LW-1:0] fwd_lo;
    logic          check_err_q;

    for (genvar g = 0; g < LANES; g++) begin : g_fwd
        SBox u_sbox (
            .data_i (sub_lo[4*g +: 4]),
            .data_o (fwd_lo[4*g +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            check_err_q <= 1'b0;
        end else if (state_q == RUN && fwd_lo != blk_q[LW-1:0]) begin
            check_err_q <= 1'b1;
        end
    end

    assign check_err = check_err_q;
`else
    assign check_err = 1'b0;
`endif

endmodule
